// File: rtl/bcd_serial_adder_ctrl.sv
// Serial BCD adder controller: sums one packed-BCD digit per cycle, LSD first.
// Optional macro BCD_DIGIT_CHECK_EN rejects operands containing digits above 9.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  error
);

    localparam int W = 4 * DIGITS;
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry, digit} for one decimal digit position.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic c);
        logic [4:0] s;
        logic [4:0] s_adj;
        s     = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        s_adj = s + 5'd6;
        if (s > 5'd9) begin
            return {1'b1, s_adj[3:0]};
        end else begin
            return {1'b0, s[3:0]};
        end
    endfunction

`ifdef BCD_DIGIT_CHECK_EN
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction
`endif

    state_t         state_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           carry_r;
    logic [3:0]     idx_r;
    logic [W-1:0]   sum_r;
    logic           cout_r;
    logic           error_r;
    logic           busy_r;
    logic           done_r;

    logic [3:0]     a_dig_s;
    logic [3:0]     b_dig_s;
    logic [4:0]     digit_s;
    logic [W-1:0]   digit_pos_s;

    // Select the current digit of each captured operand and form its placed result.
    always_comb begin
        a_dig_s     = 4'(a_r >> {idx_r, 2'b00});
        b_dig_s     = 4'(b_r >> {idx_r, 2'b00});
        digit_s     = bcd_digit_add(a_dig_s, b_dig_s, carry_r);
        digit_pos_s = W'(digit_s[3:0]) << {idx_r, 2'b00};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= 4'd0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            error_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        carry_r <= cin;
                        idx_r   <= 4'd0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        error_r <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                        if (has_bad_digit(A) || has_bad_digit(B)) begin
                            state_r <= DONE;
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ADD;
                            busy_r  <= 1'b1;
                        end
`else
                        state_r <= ADD;
                        busy_r  <= 1'b1;
`endif
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ADD: begin
                    sum_r   <= sum_r | digit_pos_s;
                    carry_r <= digit_s[4];
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        cout_r  <= digit_s[4];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;
`ifdef BCD_DIGIT_CHECK_EN
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (DIGITS=4): directed table,
// randomized operands against a decimal-arithmetic model, and multi-cycle corner sequences.
module tb_bcd_serial_adder_ctrl;

    localparam int D   = 4;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        error;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .error (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        er;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: value of the operands as integers, added, converted back.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                  output logic [15:0] s, output logic co);
        int va;
        int vb;
        int tot;
        va = 0;
        vb = 0;
        for (int i = D - 1; i >= 0; i--) begin
            va = va * 10 + int'(a[4*i +: 4]);
            vb = vb * 10 + int'(b[4*i +: 4]);
        end
        tot = va + vb + int'(ci);
        co  = (tot >= MOD);
        tot = tot % MOD;
        s   = '0;
        for (int i = 0; i < D; i++) begin
            s[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
        end
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < D; i++) begin
            v[4*i +: 4] = 4'($urandom_range(9));
        end
        return v;
    endfunction

    // One start pulse; checks latency, busy span, no busy/done overlap, result and hold.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic eco, input logic eer);
        int          lat;
        int          bcnt;
        bit          seen;
        bit          overlap;
        logic [15:0] held;
        @(negedge clk);
        A = a; B = b; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
        lat = 0; bcnt = 0; seen = 1'b0; overlap = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk({name, " done_seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(lat), eer ? 32'd1 : 32'(D + 1));
        chk({name, " busy_cycles"}, 32'(bcnt), eer ? 32'd0 : 32'(D));
        chk({name, " overlap"}, 32'(overlap), 32'd0);
        chk({name, " sum"}, 32'(sum), 32'(es));
        chk({name, " cout"}, 32'(cout), 32'(eco));
        chk({name, " error"}, 32'(error), 32'(eer));
        held = sum;
        @(negedge clk);
        @(negedge clk);
        chk({name, " done_pulse"}, 32'(done), 32'd0);
        chk({name, " sum_held"}, 32'(sum), 32'(held));
    endtask

    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [15:0] es;
    logic        eco;
    int          dcnt;
    int          first_d;
    int          second_d;
    bit          ovl;

    initial begin
        tbl[0] = '{"r031",  16'h4567, 16'h5678, 1'b0, 16'h0245, 1'b1, 1'b0};
        tbl[1] = '{"r032a", 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{"r032b", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[3] = '{"zero",  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[4] = '{"max",   16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        tbl[5] = '{"five",  16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};
`ifdef BCD_DIGIT_CHECK_EN
        tbl[6] = '{"bad",   16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
`else
        tbl[6] = '{"bad",   16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b0};
`endif

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].er);
        end

        for (int i = 0; i < 40; i++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom);
            model(ra, rb, rc, es, eco);
            do_op($sformatf("rand%0d", i), ra, rb, rc, es, eco, 1'b0);
        end

        // start held high for 12 cycles: exactly two accepted operations.
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; cin = 1'b0; start = 1'b1;
        dcnt = 0; first_d = 0; second_d = 0; ovl = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy && done) ovl = 1'b1;
            if (done) begin
                dcnt++;
                if (dcnt == 1) first_d = k;
                else second_d = k;
                chk($sformatf("held_start sum@%0d", k), 32'(sum), 32'h0002);
            end
        end
        start = 1'b0;
        chk("held_start done_count", 32'(dcnt), 32'd2);
        chk("held_start first_done", 32'(first_d), 32'd5);
        chk("held_start second_done", 32'(second_d), 32'd11);
        chk("held_start overlap", 32'(ovl), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("held_start idle_after", 32'(busy), 32'd0);

        // Asynchronous reset during the second ADD cycle.
        @(negedge clk);
        A = 16'h4567; B = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midreset busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset sum", 32'(sum), 32'd0);
        chk("midreset cout", 32'(cout), 32'd0);
        chk("midreset error", 32'(error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
